// File: rtl/gf180mcu_ocd_io__gpio_bank.sv
// N-channel GPIO bank: register port, pad-control flops, synchronised and
// debounced pad inputs, and sticky per-channel edge interrupts.
module gf180mcu_ocd_io__gpio_bank #(
  parameter int unsigned N       = 8,
  parameter int unsigned DEB_CYC = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         WE,
  input  logic         RE,
  input  logic [3:0]   ADDR,
  input  logic [N-1:0] WDATA,
  output logic [N-1:0] RDATA,
  output logic         IRQ,
  output logic [N-1:0] PAD_A,
  output logic [N-1:0] PAD_OE,
  output logic [N-1:0] PAD_IE,
  output logic [N-1:0] PAD_PU,
  output logic [N-1:0] PAD_PD,
  output logic [N-1:0] PAD_SL,
  output logic [N-1:0] PAD_CS,
  input  logic [N-1:0] PAD_Y
);

  localparam int unsigned CW = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;

  logic [N-1:0] dout, oe, ie, pu, pd, sl, cs, edge_sel, irq_en, irq_stat;
  logic [N-1:0] dout_n, oe_n, ie_n, pu_n, pd_n, sl_n, cs_n, edge_n, irq_en_n, irq_stat_n;
  logic [N-1:0] stat_clr, ev;
  logic [N-1:0] s1, s2, din, din_q;
  logic [N-1:0] rd_c;

  // Edge events: rising or falling per channel as selected by EDGE.
  assign ev = (edge_sel & din & ~din_q) | (~edge_sel & ~din & din_q);

  // Register-port next-state decode; an event on a bit beats its clear.
  always_comb begin
    dout_n   = dout;
    oe_n     = oe;
    ie_n     = ie;
    pu_n     = pu;
    pd_n     = pd;
    sl_n     = sl;
    cs_n     = cs;
    edge_n   = edge_sel;
    irq_en_n = irq_en;
    stat_clr = '0;
    if (WE) begin
      case (ADDR)
        4'd0:    dout_n   = WDATA;
        4'd1:    oe_n     = WDATA;
        4'd2:    ie_n     = WDATA;
        4'd3:    pu_n     = WDATA;
        4'd4:    pd_n     = WDATA;
        4'd5:    sl_n     = WDATA;
        4'd6:    cs_n     = WDATA;
        4'd7:    edge_n   = WDATA;
        4'd8:    irq_en_n = WDATA;
        4'd9:    stat_clr = WDATA;
        default: ;
      endcase
    end
    irq_stat_n = (irq_stat & ~stat_clr) | ev;
  end

  // Read mux on current (pre-write) register values.
  always_comb begin
    rd_c = '0;
    case (ADDR)
      4'd0:    rd_c = dout;
      4'd1:    rd_c = oe;
      4'd2:    rd_c = ie;
      4'd3:    rd_c = pu;
      4'd4:    rd_c = pd;
      4'd5:    rd_c = sl;
      4'd6:    rd_c = cs;
      4'd7:    rd_c = edge_sel;
      4'd8:    rd_c = irq_en;
      4'd9:    rd_c = irq_stat;
      4'd10:   rd_c = din;
      default: rd_c = '0;
    endcase
  end

  // Control registers, pull outputs, interrupt and read data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dout     <= '0;
      oe       <= '0;
      ie       <= '0;
      pu       <= '0;
      pd       <= '0;
      sl       <= '0;
      cs       <= '0;
      edge_sel <= '0;
      irq_en   <= '0;
      irq_stat <= '0;
      PAD_PU   <= '0;
      PAD_PD   <= '0;
      IRQ      <= 1'b0;
      RDATA    <= '0;
      din_q    <= '0;
    end else begin
      dout     <= dout_n;
      oe       <= oe_n;
      ie       <= ie_n;
      pu       <= pu_n;
      pd       <= pd_n;
      sl       <= sl_n;
      cs       <= cs_n;
      edge_sel <= edge_n;
      irq_en   <= irq_en_n;
      irq_stat <= irq_stat_n;
      PAD_PU   <= pu_n & ~pd_n;
      PAD_PD   <= pd_n & ~pu_n;
      IRQ      <= |(irq_stat_n & irq_en_n);
      if (RE) RDATA <= rd_c;
      din_q    <= din;
    end
  end

  assign PAD_A  = dout;
  assign PAD_OE = oe;
  assign PAD_IE = ie;
  assign PAD_SL = sl;
  assign PAD_CS = cs;

  // Two-flop synchroniser, held at zero on channels with input disabled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= PAD_Y & ie;
      s2 <= s1 & ie;
    end
  end

  generate
    if (DEB_CYC == 0) begin : g_nodeb
      assign din = s2;
    end else begin : g_deb
      logic [CW-1:0] cnt [N];
      // Per-channel debounce: DIN follows s2 only after DEB_CYC stable cycles.
      always_ff @(posedge CLK) begin
        if (RST) begin
          din <= '0;
          for (int i = 0; i < int'(N); i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < int'(N); i++) begin
            if (!ie[i]) begin
              din[i] <= 1'b0;
              cnt[i] <= '0;
            end else if (s2[i] == din[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == CW'(DEB_CYC - 1)) begin
              din[i] <= s2[i];
              cnt[i] <= '0;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_gf180mcu_ocd_io__gpio_bank.sv
// Directed bench for gf180mcu_ocd_io__gpio_bank (N=8, DEB_CYC=4).
module tb_gf180mcu_ocd_io__gpio_bank;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       WE = 1'b0, RE = 1'b0;
  logic [3:0] ADDR = '0;
  logic [7:0] WDATA = '0;
  logic [7:0] RDATA;
  logic       IRQ;
  logic [7:0] PAD_A, PAD_OE, PAD_IE, PAD_PU, PAD_PD, PAD_SL, PAD_CS;
  logic [7:0] PAD_Y = '0;

  gf180mcu_ocd_io__gpio_bank #(.N(8), .DEB_CYC(4)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .RE(RE), .ADDR(ADDR), .WDATA(WDATA),
    .RDATA(RDATA), .IRQ(IRQ), .PAD_A(PAD_A), .PAD_OE(PAD_OE), .PAD_IE(PAD_IE),
    .PAD_PU(PAD_PU), .PAD_PD(PAD_PD), .PAD_SL(PAD_SL), .PAD_CS(PAD_CS),
    .PAD_Y(PAD_Y)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [55:0] pads;
    logic        irq;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic we, input logic re, input logic [3:0] addr,
                              input logic [7:0] wdata, input logic [7:0] rdata,
                              input logic [7:0] a, input logic [7:0] oe, input logic [7:0] ie,
                              input logic [7:0] pu, input logic [7:0] pd, input logic [7:0] sl,
                              input logic [7:0] cs, input logic irq);
    vec_t v;
    v.we = we; v.re = re; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.pads = {a, oe, ie, pu, pd, sl, cs};
    v.irq = irq;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock with the given port request; outputs are sampled 1 ns after the edge.
  task automatic cyc(input logic we, input logic re, input logic [3:0] a, input logic [7:0] d);
    WE = we; RE = re; ADDR = a; WDATA = d;
    @(posedge CLK);
    #1;
    WE = 1'b0; RE = 1'b0;
  endtask

  function automatic logic [55:0] pads_now();
    return {PAD_A, PAD_OE, PAD_IE, PAD_PU, PAD_PD, PAD_SL, PAD_CS};
  endfunction

  initial begin
    // Register-port vectors: {we, re, addr, wdata} -> {rdata, pads a..cs, irq}
    for (int k = 0; k <= 10; k++)
      tbl.push_back(mk(0, 1, 4'(k), 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 0, 4'd1,  8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 0, 4'd0,  8'hA5, 8'h00, 8'hA5, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 0, 4'd3,  8'h0F, 8'h00, 8'hA5, 8'hFF, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 0, 4'd4,  8'h0F, 8'h00, 8'hA5, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 1, 4'd3,  8'h00, 8'h0F, 8'hA5, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 1, 4'd4,  8'h00, 8'h0F, 8'hA5, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 0, 4'd4,  8'h03, 8'h0F, 8'hA5, 8'hFF, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 0, 4'd3,  8'h00, 8'h0F, 8'hA5, 8'hFF, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 4'd0,  8'h3C, 8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 1, 4'd0,  8'h00, 8'h3C, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 0, 4'd5,  8'hAA, 8'h3C, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h03, 8'hAA, 8'h00, 0));
    tbl.push_back(mk(1, 0, 4'd6,  8'h55, 8'h3C, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h03, 8'hAA, 8'h55, 0));
    tbl.push_back(mk(1, 0, 4'd12, 8'hFF, 8'h3C, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h03, 8'hAA, 8'h55, 0));
    tbl.push_back(mk(0, 1, 4'd5,  8'h00, 8'hAA, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h03, 8'hAA, 8'h55, 0));
    tbl.push_back(mk(0, 1, 4'd12, 8'h00, 8'h00, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h03, 8'hAA, 8'h55, 0));
    tbl.push_back(mk(1, 0, 4'd10, 8'hFF, 8'h00, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h03, 8'hAA, 8'h55, 0));
    tbl.push_back(mk(0, 1, 4'd6,  8'h00, 8'h55, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h03, 8'hAA, 8'h55, 0));
    tbl.push_back(mk(0, 1, 4'd10, 8'h00, 8'h00, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h03, 8'hAA, 8'h55, 0));
    tbl.push_back(mk(1, 0, 4'd8,  8'hFF, 8'h00, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h03, 8'hAA, 8'h55, 0));
    tbl.push_back(mk(0, 1, 4'd8,  8'h00, 8'hFF, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h03, 8'hAA, 8'h55, 0));
    tbl.push_back(mk(1, 0, 4'd8,  8'h00, 8'hFF, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h03, 8'hAA, 8'h55, 0));
    tbl.push_back(mk(1, 0, 4'd4,  8'h00, 8'hFF, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h55, 0));
    tbl.push_back(mk(1, 0, 4'd1,  8'h00, 8'hFF, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h55, 0));

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    check("reset pads", 64'(pads_now()), 64'd0);
    check("reset irq", 64'(IRQ), 64'd0);
    check("reset rdata", 64'(RDATA), 64'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata);
      check($sformatf("vec%0d rdata", i), 64'(RDATA), 64'(tbl[i].rdata));
      check($sformatf("vec%0d pads", i), 64'(pads_now()), 64'(tbl[i].pads));
      check($sformatf("vec%0d irq", i), 64'(IRQ), 64'(tbl[i].irq));
    end

    // Channel 0: input enabled, rising edge, interrupt enabled
    cyc(1, 0, 4'd2, 8'h01);
    cyc(1, 0, 4'd7, 8'h01);
    cyc(1, 0, 4'd8, 8'h01);
    check("ie pad", 64'(PAD_IE), 64'h01);

    // Rising-input latency: RDATA(DIN) and IRQ both show it 6 edges after edge e
    PAD_Y = 8'h01;
    for (int k = 0; k <= 7; k++) begin
      cyc(0, 1, 4'd10, 8'h00);
      check($sformatf("rise k%0d din", k), 64'(RDATA), (k >= 6) ? 64'd1 : 64'd0);
      check($sformatf("rise k%0d irq", k), 64'(IRQ), (k >= 6) ? 64'd1 : 64'd0);
    end
    cyc(0, 1, 4'd9, 8'h00);
    check("stat after rise", 64'(RDATA), 64'h01);

    // Plain write-1-to-clear
    cyc(1, 0, 4'd9, 8'h01);
    check("clear irq", 64'(IRQ), 64'd0);
    cyc(0, 1, 4'd9, 8'h00);
    check("clear stat", 64'(RDATA), 64'h00);

    // Falling input with EDGE=rising: no interrupt
    PAD_Y = 8'h00;
    repeat (10) cyc(0, 0, 4'd0, 8'h00);
    check("fall no irq", 64'(IRQ), 64'd0);

    // Three-cycle glitch is filtered
    PAD_Y = 8'h01;
    repeat (3) cyc(0, 0, 4'd0, 8'h00);
    PAD_Y = 8'h00;
    for (int k = 0; k < 10; k++) begin
      cyc(0, 1, 4'd10, 8'h00);
      check($sformatf("glitch k%0d irq", k), 64'(IRQ), 64'd0);
    end
    check("glitch din", 64'(RDATA), 64'h00);
    cyc(0, 1, 4'd9, 8'h00);
    check("glitch stat", 64'(RDATA), 64'h00);

    // Four-cycle pulse is accepted
    PAD_Y = 8'h01;
    repeat (4) cyc(0, 0, 4'd0, 8'h00);
    PAD_Y = 8'h00;
    repeat (12) cyc(0, 0, 4'd0, 8'h00);
    check("pulse4 irq", 64'(IRQ), 64'd1);
    cyc(0, 1, 4'd9, 8'h00);
    check("pulse4 stat", 64'(RDATA), 64'h01);

    // Clear landing on the same edge as a new rising event: set wins
    PAD_Y = 8'h01;
    repeat (6) cyc(0, 0, 4'd0, 8'h00);
    cyc(1, 0, 4'd9, 8'h01);
    check("setwins irq", 64'(IRQ), 64'd1);
    cyc(0, 1, 4'd9, 8'h00);
    check("setwins stat", 64'(RDATA), 64'h01);
    cyc(1, 0, 4'd9, 8'h01);
    check("clear2 irq", 64'(IRQ), 64'd0);
    cyc(0, 1, 4'd9, 8'h00);
    check("clear2 stat", 64'(RDATA), 64'h00);

    // Reset while the debounce count is 2
    PAD_Y = 8'h00;
    repeat (9) cyc(0, 0, 4'd0, 8'h00);
    cyc(0, 1, 4'd5, 8'h00);
    check("pre-reset rdata", 64'(RDATA), 64'hAA);
    PAD_Y = 8'h01;
    repeat (4) cyc(0, 0, 4'd0, 8'h00);
    RST = 1'b1;
    cyc(0, 0, 4'd0, 8'h00);
    RST = 1'b0;
    check("midreset pads", 64'(pads_now()), 64'd0);
    check("midreset irq", 64'(IRQ), 64'd0);
    check("midreset rdata", 64'(RDATA), 64'd0);
    cyc(0, 1, 4'd2, 8'h00);
    check("midreset ie", 64'(RDATA), 64'd0);
    cyc(0, 1, 4'd8, 8'h00);
    check("midreset irq_en", 64'(RDATA), 64'd0);
    repeat (8) cyc(0, 0, 4'd0, 8'h00);
    cyc(0, 1, 4'd10, 8'h00);
    check("midreset din gated", 64'(RDATA), 64'd0);

    // Re-enable IE: DIN requalifies 2+DEB_CYC edges after the write
    cyc(1, 0, 4'd2, 8'h01);
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 1, 4'd10, 8'h00);
      check($sformatf("requal k%0d din", k), 64'(RDATA), (k >= 7) ? 64'd1 : 64'd0);
    end
    check("requal irq", 64'(IRQ), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gf180mcu_ocd_io__gpio_bank.md
# gf180mcu_ocd_io__gpio_bank

Parametrised N-channel GPIO controller that drives a row of bidirectional pad cells (`A`, `OE`, `IE`, `PU`, `PD`, `SL`, `CS` per channel) from a simple synchronous register port. It registers all pad controls and synchronises and debounces each pad's `Y` return. It also detects per-channel edges, holding them as sticky, maskable interrupt status. It sits between the core-side peripheral bus and the I/O ring.

## Interface
- `N`, 8: channel count, 1..32.
- `DEB_CYC`, 4: debounce stable-cycle count, 0..255. 0 bypasses the debounce stage.
- `CLK` input 1: the block's only clock; every flop is clocked on its rising edge.
- `RST` input 1: reset, synchronous, active-high.
- `WE` input 1: register write strobe.
- `RE` input 1: register read strobe.
- `ADDR` input 4: register address.
- `WDATA` input N: write data.
- `RDATA` output N: read data, registered.
- `IRQ` output 1: interrupt, registered.
- `PAD_A` output N: per-channel pad `A`.
- `PAD_OE` output N: per-channel pad `OE`.
- `PAD_IE` output N: per-channel pad `IE`.
- `PAD_PU` output N: per-channel pad `PU`.
- `PAD_PD` output N: per-channel pad `PD`.
- `PAD_SL` output N: per-channel pad `SL`.
- `PAD_CS` output N: per-channel pad `CS`.
- `PAD_Y` input N: per-channel pad `Y`; asynchronous to `CLK`.

## Operation
- Register map (N bits each, R/W unless noted):
  - 0 `DOUT`
  - 1 `OE`
  - 2 `IE`
  - 3 `PU`
  - 4 `PD`
  - 5 `SL`
  - 6 `CS`
  - 7 `EDGE` (1 = rising, 0 = falling)
  - 8 `IRQ_EN`
  - 9 `IRQ_STAT` (write-1-to-clear)
  - 10 `DIN` (read-only)
  - 11..15: read 0, writes ignored.
- Write to a read-only or unmapped address: ignored.
- Pad-control outputs:
  - `PAD_A`, `PAD_OE`, `PAD_IE`, `PAD_SL` and `PAD_CS` are direct flop outputs of `DOUT`, `OE`, `IE`, `SL` and `CS`.
  - `PAD_PU` = `PU` & ~`PD`; `PAD_PD` = `PD` & ~`PU`. Both set means both outputs are 0, so no contending pulls. The registers still read back the written values.
- Input path per channel: `PAD_Y` → 2-flop synchroniser (s1, s2) → debounce → `DIN`.
- Debounce (`DEB_CYC` > 0), evaluated each cycle:
  - s2 == `DIN`: count cleared.
  - s2 != `DIN` and count == `DEB_CYC`-1: `DIN` <= s2, count cleared.
  - Otherwise: count increments.
  - Count width is ceil(log2(max(`DEB_CYC`,2))), with no wrap.
- `DEB_CYC` = 0: `DIN` = s2.
- IE gating: a channel whose `IE` bit is 0 holds s1, s2, `DIN` and its count at 0.
- Edge detect: `DIN` is compared with its previous-cycle value `DIN_q`.
  - An event is `DIN` & ~`DIN_q` when `EDGE`=1, or ~`DIN` & `DIN_q` when `EDGE`=0.
  - An event sets the `IRQ_STAT` bit whatever `IRQ_EN` holds.
  - Enabling `IE` on a pad already high produces a rising event, which software clears.
- `IRQ_STAT` clear: a write of 1 clears the bit. If a set event and a clear land in the same cycle, the set wins.
- `IRQ` <= |(`IRQ_STAT` & `IRQ_EN`), evaluated on next-state values.
- Read: `RE` at edge t gives `RDATA` = addressed value at t+1. Without `RE`, `RDATA` holds its last value.
- Simultaneous `WE` and `RE` to the same address: `RDATA` returns the pre-write value.

## Timing
- Reset: all registers, s1/s2, `DIN`, `DIN_q`, counts, `RDATA` and `IRQ` are 0. Every `PAD_*` output is 0: pads tri-stated, input disabled, no pulls.
- `RST` mid-debounce or mid-interrupt returns everything to the reset state at that edge. Pending events are discarded.
- Write latency: `WE` sampled at edge t; the `PAD_*` output changes after edge t.
- Input latency: a `PAD_Y` change setting up before edge e reaches `DIN` after edge e+1+`DEB_CYC`. It sets `IRQ_STAT` after edge e+2+`DEB_CYC` and `IRQ` after that same edge.
- A glitch shorter than `DEB_CYC` cycles at s2 leaves `DIN` unchanged.
- Read latency: 1 cycle.

## Test plan
- Reset, then read all 11 addresses: all 0, every `PAD_*` = 0, `IRQ` = 0.
- Write `OE`=0xFF, `DOUT`=0xA5 (N=8): `PAD_OE`=0xFF and `PAD_A`=0xA5 one cycle after `WE`. Write `PU`=`PD`=0x0F: `PAD_PU`=`PAD_PD`=0x00, and `PU` reads back 0x0F.
- `DEB_CYC`=4, `IE`=0x01, `EDGE`=0x01, `IRQ_EN`=0x01. Raise `PAD_Y[0]` before edge 10: `DIN[0]`=1 after edge 15, `IRQ_STAT[0]`=1 and `IRQ`=1 after edge 16.
- Same setup: pulse `PAD_Y[0]` high for 3 cycles. `DIN` stays 0, `IRQ` stays 0.
- With `IRQ_STAT[0]`=1, write 9←0x01 in the same cycle as a new rising event on channel 0: bit stays 1. Write again with no event: bit cleared and `IRQ`=0 next cycle.
- Assert `RST` for one cycle while a debounce count is 2: all state 0 afterwards. `DIN` re-qualifies only after `IE` is rewritten and the full 2+`DEB_CYC` latency elapses.
